mem_bridge: RTL and testbench

Memory bus bridge sitting between the CPU core and the external 8-bit memory bus. It consumes the 16-bit effective address produced by the address generation unit, plus the access request from the control unit, and executes the access as one or two byte beats over a strobe/acknowledge bus with unbounded wait states. It returns read data and a completion pulse to the core.

---
 rtl/mem_bridge.sv | 195 +++++++++++++++++++
 tb/tb_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: executes 8/16-bit CPU accesses as one or two byte beats on a strobe/ack memory bus.
// Optional per-beat wait timeout is enabled by defining MEM_BRIDGE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for cpu_req; request fields latched on accept
// LO     | first beat: byte at adr, wdata[7:0]
// HI     | second beat of a word: byte at adr+1, wdata[15:8]
// DONE   | one-cycle completion pulse, read result published

module mem_bridge #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_adr,
  input  logic [15:0] cpu_wdata,
  output logic        busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_dout,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_din,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT must be in 1..255");
  end

  logic [1:0]  state_q, state_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        cpu_done_q, cpu_done_d;
  logic        cpu_err_q, cpu_err_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] mem_adr_q, mem_adr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        beat_d;
  logic        timeout_hit;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Abort fires on the TIMEOUT-th unacknowledged cycle; an ack in that cycle takes priority.
  assign timeout_hit = (wait_cnt_q == TO_LAST);

  always_comb begin
    wait_cnt_d = 8'd0;
    if ((state_d == state_q) && ((state_q == S_LO) || (state_q == S_HI))) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    byte_d      = byte_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          wr_d    = cpu_wr;
          byte_d  = cpu_byte;
          adr_d   = cpu_adr;
          wdata_d = cpu_wdata;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (mem_ack) begin
          rbuf_d = mem_din;
          if (byte_q) begin
            state_d = S_DONE;
            if (!wr_q) cpu_rdata_d = {8'h00, mem_din};
          end else begin
            state_d = S_HI;
          end
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          cpu_err_d = 1'b1;
          if (!wr_q) cpu_rdata_d = 16'hFFFF;
        end
      end
      S_HI: begin
        if (mem_ack) begin
          state_d = S_DONE;
          if (!wr_q) cpu_rdata_d = {mem_din, rbuf_q};
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          cpu_err_d = 1'b1;
          if (!wr_q) cpu_rdata_d = 16'hFFFF;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cpu_done_d = (state_d == S_DONE);

    // Bus outputs are registered from the next state so they line up with the beat cycles.
    beat_d   = (state_d == S_LO) || (state_d == S_HI);
    mem_rd_d = beat_d && !wr_d;
    mem_wr_d = beat_d && wr_d;

    mem_adr_d  = mem_adr_q;
    mem_dout_d = mem_dout_q;
    if (state_d == S_LO) begin
      mem_adr_d  = adr_d;
      mem_dout_d = wdata_d[7:0];
    end else if (state_d == S_HI) begin
      mem_adr_d  = adr_q + 16'd1;
      mem_dout_d = wdata_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      adr_q       <= 16'h0000;
      wdata_q     <= 16'h0000;
      rbuf_q      <= 8'h00;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 16'h0000;
      mem_adr_q   <= 16'h0000;
      mem_dout_q  <= 8'h00;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      byte_q      <= byte_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_adr_q   <= mem_adr_d;
      mem_dout_q  <= mem_dout_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign cpu_done  = cpu_done_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_adr   = mem_adr_q;
  assign mem_dout  = mem_dout_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: directed and randomized accesses against a byte-array memory model.
// Timeout scenarios are compiled in when MEM_BRIDGE_TIMEOUT_EN is defined.

module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wr, cpu_byte;
  logic [15:0] cpu_adr, cpu_wdata;
  logic        busy, cpu_done, cpu_err;
  logic [15:0] cpu_rdata, mem_adr;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_rd, mem_wr, mem_ack;

  logic [7:0]  bus_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] exp_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_byte  (cpu_byte),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .busy      (busy),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .mem_adr   (mem_adr),
    .mem_dout  (mem_dout),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack)
  );

  // One complete access: request, per-cycle beat checks with w_lo/w_hi wait cycles, then DONE.
  task automatic do_access(input logic wr, input logic byt, input logic [15:0] adr,
                           input logic [15:0] wdata, input int w_lo, input int w_hi,
                           input logic poke, input string tag);
    logic [15:0] badr [2];
    logic [7:0]  bdout [2];
    int          bw [2];
    int          nb;
    nb       = byt ? 1 : 2;
    badr[0]  = adr;
    badr[1]  = adr + 16'd1;
    bdout[0] = wdata[7:0];
    bdout[1] = wdata[15:8];
    bw[0]    = w_lo;
    bw[1]    = w_hi;
    if (wr) begin
      ref_mem[badr[0]] = wdata[7:0];
      if (!byt) ref_mem[badr[1]] = wdata[15:8];
    end else begin
      exp_rdata = byt ? {8'h00, ref_mem[badr[0]]} : {ref_mem[badr[1]], ref_mem[badr[0]]};
    end

    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL %s idle_before_req busy=%b want 0", tag, busy); n_fail++;
    end
    cpu_req = 1'b1; cpu_wr = wr; cpu_byte = byt; cpu_adr = adr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = poke; cpu_wr = $urandom; cpu_byte = $urandom;
    cpu_adr = 16'($urandom); cpu_wdata = 16'($urandom);

    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w <= bw[b]; w++) begin
        n_checks++;
        if ({mem_rd, mem_wr, busy, cpu_done} !== {~wr, wr, 1'b1, 1'b0}) begin
          $display("FAIL %s beat%0d_ctl rd/wr/busy/done=%b%b%b%b want %b%b10",
                   tag, b, mem_rd, mem_wr, busy, cpu_done, ~wr, wr); n_fail++;
        end
        n_checks++;
        if (mem_adr !== badr[b]) begin
          $display("FAIL %s beat%0d_adr got %h want %h", tag, b, mem_adr, badr[b]); n_fail++;
        end
        if (wr) begin
          n_checks++;
          if (mem_dout !== bdout[b]) begin
            $display("FAIL %s beat%0d_dout got %h want %h", tag, b, mem_dout, bdout[b]); n_fail++;
          end
        end
        if (w == bw[b]) begin
          mem_ack = 1'b1;
          if (wr) bus_mem[mem_adr] = mem_dout;
          else    mem_din = bus_mem[mem_adr];
        end else begin
          mem_ack = 1'b0;
          mem_din = 8'($urandom);
        end
        @(negedge clk);
      end
    end

    mem_ack = 1'($urandom);
    mem_din = 8'($urandom);
    n_checks++;
    if ({cpu_done, cpu_err, mem_rd, mem_wr, busy} !== 5'b10001) begin
      $display("FAIL %s done_cycle done/err/rd/wr/busy=%b%b%b%b%b want 10001",
               tag, cpu_done, cpu_err, mem_rd, mem_wr, busy); n_fail++;
    end
    n_checks++;
    if (cpu_rdata !== exp_rdata) begin
      $display("FAIL %s rdata got %h want %h", tag, cpu_rdata, exp_rdata); n_fail++;
    end
    cpu_req = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if ({cpu_done, busy, mem_rd, mem_wr} !== 4'b0000) begin
      $display("FAIL %s after_done done/busy/rd/wr=%b%b%b%b want 0000",
               tag, cpu_done, busy, mem_rd, mem_wr); n_fail++;
    end
    if (poke) begin
      @(negedge clk);
      n_checks++;
      if ({busy, mem_rd, mem_wr} !== 3'b000) begin
        $display("FAIL %s req_during_busy_ignored busy/rd/wr=%b%b%b want 000",
                 tag, busy, mem_rd, mem_wr); n_fail++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    mem_din = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, cpu_done, cpu_err, mem_rd, mem_wr} !== 5'b00000) begin
      $display("FAIL reset_ctl busy/done/err/rd/wr=%b%b%b%b%b want 00000",
               busy, cpu_done, cpu_err, mem_rd, mem_wr); n_fail++;
    end
    n_checks++;
    if ({cpu_rdata, mem_adr, mem_dout} !== 40'h0) begin
      $display("FAIL reset_data rdata=%h adr=%h dout=%h want 0", cpu_rdata, mem_adr, mem_dout);
      n_fail++;
    end
    rst_n = 1'b1;
    exp_rdata = 16'h0000;
  endtask

  task automatic test_byte_read();
    bus_mem[16'h1234] = 8'hAB;
    ref_mem[16'h1234] = 8'hAB;
    do_access(1'b0, 1'b1, 16'h1234, 16'($urandom), 0, 0, 1'b0, "byte_read");
    n_checks++;
    if (cpu_rdata !== 16'h00AB) begin
      $display("FAIL byte_read_value got %h want 00ab", cpu_rdata); n_fail++;
    end
  endtask

  task automatic test_word_write_wrap();
    do_access(1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 2, 2, 1'b0, "word_write_wrap");
    n_checks++;
    if ({bus_mem[16'hFFFF], bus_mem[16'h0000]} !== 16'hEFBE) begin
      $display("FAIL word_write_wrap_mem got %h%h want efbe", bus_mem[16'hFFFF], bus_mem[16'h0000]);
      n_fail++;
    end
  endtask

  task automatic test_word_read_busy();
    bus_mem[16'h0100] = 8'h34; ref_mem[16'h0100] = 8'h34;
    bus_mem[16'h0101] = 8'h12; ref_mem[16'h0101] = 8'h12;
    do_access(1'b0, 1'b0, 16'h0100, 16'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), 1'b1, "word_read_busy");
    n_checks++;
    if (cpu_rdata !== 16'h1234) begin
      $display("FAIL word_read_value got %h want 1234", cpu_rdata); n_fail++;
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 60; i++) begin
      a = 16'hFFF0 + 16'($urandom_range(0, 31));
      do_access(1'($urandom), 1'($urandom), a, 16'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

`ifndef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_long_wait();
    do_access(1'b0, 1'b0, 16'h4000, 16'h0, 40, 3, 1'b0, "long_wait");
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_adr = 16'h0200;
    @(negedge clk);
    cpu_req = 1'b0;
    mem_ack = 1'b1; mem_din = 8'h5A;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if ({mem_rd, mem_adr} !== {1'b1, 16'h0201}) begin
      $display("FAIL reset_mid_hi_beat rd=%b adr=%h want 1 0201", mem_rd, mem_adr); n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_rd, mem_wr, busy, cpu_done} !== 4'b0000) begin
      $display("FAIL reset_mid_strobes rd/wr/busy/done=%b%b%b%b want 0000",
               mem_rd, mem_wr, busy, cpu_done); n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 16'h0000;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_rd, cpu_rdata} !== 18'h0) begin
      $display("FAIL reset_mid_after busy=%b rd=%b rdata=%h want 0 0 0000", busy, mem_rd, cpu_rdata);
      n_fail++;
    end
  endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_byte = 1'b0; cpu_adr = 16'h3000;
    @(negedge clk);
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if ({mem_rd, mem_adr, cpu_done} !== {1'b1, 16'h3000, 1'b0}) begin
        $display("FAIL timeout_wait%0d rd=%b adr=%h done=%b want 1 3000 0",
                 i, mem_rd, mem_adr, cpu_done); n_fail++;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({cpu_done, cpu_err, mem_rd, mem_wr} !== 4'b1100) begin
      $display("FAIL timeout_abort done/err/rd/wr=%b%b%b%b want 1100",
               cpu_done, cpu_err, mem_rd, mem_wr); n_fail++;
    end
    n_checks++;
    if (cpu_rdata !== 16'hFFFF) begin
      $display("FAIL timeout_rdata got %h want ffff", cpu_rdata); n_fail++;
    end
    exp_rdata = 16'hFFFF;
    @(negedge clk);
    n_checks++;
    if ({busy, cpu_done, cpu_err, mem_rd} !== 4'b0000) begin
      $display("FAIL timeout_no_hi busy/done/err/rd=%b%b%b%b want 0000",
               busy, cpu_done, cpu_err, mem_rd); n_fail++;
    end
  endtask

  task automatic test_timeout_ack_edge();
    do_access(1'b0, 1'b0, 16'h3100, 16'h0, 14, 14, 1'b0, "timeout_ack_edge");
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    test_reset();
    test_byte_read();
    test_word_write_wrap();
    test_word_read_busy();
    test_random();
`ifndef MEM_BRIDGE_TIMEOUT_EN
    test_long_wait();
`endif
    test_reset_mid();
`ifdef MEM_BRIDGE_TIMEOUT_EN
    test_timeout();
    test_timeout_ack_edge();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
